mem_miss_engine: RTL and testbench
==================================

Name: mem_miss_engine

Overview:
- Cache-side initiator for the slow-memory block protocol (mem_read/mem_write/mem_addr[31:4]/128-bit data/mem_ready).
- Sits between an L1/L2 cache controller and a slow_memory instance.
- Accepts one miss request at a time. If the victim line is dirty, writes it back first, then refills the missed line and returns it to the cache.
- Adds a per-transaction watchdog so a stalled memory is reported rather than hanging the pipeline.

Parameters:
- ADDR_W, 28, line address width (bits [31:4]).
- LINE_W, 128, cache line width in bits.
- TIMEOUT_CYCLES, 1023, maximum cycles waiting for mem_ready before aborting (must be ≥1).
- CNT_W, 10, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  cache presents a miss.
- req_ready  out  1  engine can accept a request (high only in IDLE).
- req_addr  in  ADDR_W  missed line address.
- req_dirty  in  1  victim line must be written back.
- req_victim_addr  in  ADDR_W  victim line address.
- req_victim_data  in  LINE_W  victim line data.
- resp_valid  out  1  one-cycle pulse: refill data valid.
- resp_data  out  LINE_W  refilled line.
- resp_err  out  1  one-cycle pulse: transaction aborted by timeout.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory line address.
- mem_wdata  out  LINE_W  memory write data.
- mem_rdata  in  LINE_W  memory read data, valid when mem_ready=1.
- mem_ready  in  1  memory completion, one-cycle pulse.

Behaviour:
- Reset values: all outputs 0, except req_ready=1 (IDLE). Internal registers, the watchdog and the state register are cleared.
- Reset mid-transaction aborts immediately. No resp pulse is produced, and mem_read/mem_write drop asynchronously.
- States: IDLE, WB, GAP, RD, RESP, ERR.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_addr, req_victim_addr and req_victim_data.
  - Go to WB if req_dirty, else RD. Handshake completes in that cycle.
- WB:
  - mem_write=1, mem_addr=victim address, mem_wdata=victim data, all held stable.
  - On mem_ready, go to GAP.
- GAP: one cycle with mem_read=mem_write=0. Guarantees the strobe deasserts between back-to-back accesses. Then go to RD.
- RD:
  - mem_read=1, mem_addr=latched req_addr.
  - On mem_ready, capture mem_rdata into resp_data and go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_data holds its value until the next capture.
- ERR: resp_err=1 for one cycle with strobes low, then IDLE.
- mem_read and mem_write are registered outputs and are never high simultaneously.
- Watchdog:
  - Cleared on entry to WB and RD; increments each cycle in WB or RD while mem_ready=0.
  - When it reaches TIMEOUT_CYCLES without mem_ready, go to ERR. A writeback timeout skips the refill.
  - mem_ready arriving in the same cycle as the limit wins: normal progression.
- Latency, with memory latency L = cycles from strobe assertion to mem_ready inclusive:
  - clean miss: resp_valid L+1 cycles after the request handshake.
  - dirty miss: 2L+2 cycles.
- mem_ready outside WB/RD is ignored.
- req_valid outside IDLE is ignored; the cache must hold it.
- req_addr equal to req_victim_addr with dirty=1 is legal: writeback completes first, so the refill returns the written data.

Optional Feature:
- Macro MISS_ENGINE_STATS_EN.
- Defined:
  - Adds outputs stat_refills[15:0], stat_writebacks[15:0] and stat_stall_cycles[31:0], all reset to 0.
  - Counts completed RD, completed WB, and cycles spent outside IDLE.
  - Counters saturate at all-ones and never wrap.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mem_if_pkg: state encoding enum, ADDR_W/LINE_W constants, and the line-address typedef shared with caches and slow_memory.
- One natural sub-module: mem_watchdog (load/clear, count-enable, limit compare, expired pulse), reusable by other memory initiators.
- FSM and datapath stay in mem_miss_engine.

Test Plan:
- Clean miss, memory latency 5, req_addr=0x0000010 → mem_read high for 5 cycles with mem_addr=0x0000010, mem_write never high; resp_valid pulses once on cycle 6 with resp_data = memory line.
- Dirty miss, victim 0x0000020 with data 0xDEADBEEF_…, refill 0x0000030 → write of the victim completes first, one idle GAP cycle, then read of 0x0000030; resp at cycle 2L+2; memory holds the victim data.
- Dirty miss where victim address equals refill address 0x0000040 → resp_data equals the victim data just written.
- Memory never asserts mem_ready with TIMEOUT_CYCLES=8 → strobe held 8 cycles, resp_err pulses once, no resp_valid, req_ready returns to 1.
- Assert rst during RD → mem_read=0 asynchronously, state IDLE, no resp_valid; the next request completes normally.
- With MISS_ENGINE_STATS_EN, 3 clean and 2 dirty misses → stat_refills=5, stat_writebacks=2; stat_stall_cycles equals the measured busy cycles.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared slow-memory block protocol definitions: line address/data widths,
// the line-address and line-data types, and the miss engine state encoding.
package mem_if_pkg;

    localparam int MEM_ADDR_W = 28;   // line address, byte address bits [31:4]
    localparam int MEM_LINE_W = 128;  // one cache line per transfer

    typedef logic [MEM_ADDR_W-1:0] line_addr_t;
    typedef logic [MEM_LINE_W-1:0] line_data_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WB   = 3'd1,
        ST_GAP  = 3'd2,
        ST_RD   = 3'd3,
        ST_RESP = 3'd4,
        ST_ERR  = 3'd5
    } miss_state_t;

endpackage

// File: rtl/mem_watchdog.sv
// Per-transaction stall watchdog for memory initiators.
// clear restarts the count; count_en marks a cycle spent waiting. expired is
// asserted combinationally on the LIMIT-th consecutive waiting cycle, so the
// owner can leave its wait state on that same clock edge.
module mem_watchdog #(
    parameter int LIMIT = 1023,
    parameter int CNT_W = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    // Count waiting cycles; hold at LAST so the counter can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (count_en && count != LAST)
            count <= count + CNT_W'(1);
    end

    assign expired = count_en && !clear && (count == LAST);

endmodule

// File: rtl/mem_miss_engine.sv
// Cache miss engine: optional dirty-victim writeback, then line refill, each
// access guarded by a watchdog that turns a stalled memory into resp_err.
// Optional statistics counters are built when MISS_ENGINE_STATS_EN is defined.
module mem_miss_engine
    import mem_if_pkg::*;
#(
    parameter int ADDR_W         = MEM_ADDR_W,
    parameter int LINE_W         = MEM_LINE_W,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_dirty,
    input  logic [ADDR_W-1:0] req_victim_addr,
    input  logic [LINE_W-1:0] req_victim_data,
    output logic              resp_valid,
    output logic [LINE_W-1:0] resp_data,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef MISS_ENGINE_STATS_EN
    ,
    output logic [15:0]       stat_refills,
    output logic [15:0]       stat_writebacks,
    output logic [31:0]       stat_stall_cycles
`endif
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] victim_addr;
        logic [LINE_W-1:0] victim_data;
    } miss_req_t;

    miss_state_t state_q, state_d;
    miss_req_t   req_q;
    logic        hs;
    logic        wd_clear, wd_en, wd_expired;

    assign hs = (state_q == ST_IDLE) && req_valid;

    // Restart the watchdog on every entry into a memory access; count only
    // the cycles the access is still waiting.
    assign wd_clear = ((state_d == ST_WB) || (state_d == ST_RD)) && (state_d != state_q);
    assign wd_en    = ((state_q == ST_WB) || (state_q == ST_RD)) && !mem_ready;

    mem_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (wd_clear),
        .count_en (wd_en),
        .expired  (wd_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next state; mem_ready wins over a watchdog expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = req_dirty ? ST_WB : ST_RD;
            ST_WB: begin
                if (mem_ready)       state_d = ST_GAP;
                else if (wd_expired) state_d = ST_ERR;
            end
            ST_GAP:  state_d = ST_RD;
            ST_RD: begin
                if (mem_ready)       state_d = ST_RESP;
                else if (wd_expired) state_d = ST_ERR;
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch the whole miss at the handshake; the cache may change its inputs after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            req_q <= '0;
        else if (hs)
            req_q <= '{addr: req_addr, victim_addr: req_victim_addr, victim_data: req_victim_data};
    end

    // Registered control outputs decoded from the next state, so strobes and
    // pulses line up exactly with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready  <= 1'b1;
            mem_write  <= 1'b0;
            mem_read   <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            req_ready  <= (state_d == ST_IDLE);
            mem_write  <= (state_d == ST_WB);
            mem_read   <= (state_d == ST_RD);
            resp_valid <= (state_d == ST_RESP);
            resp_err   <= (state_d == ST_ERR);
        end
    end

    // Refill data is captured on read completion and held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            resp_data <= '0;
        else if ((state_q == ST_RD) && mem_ready)
            resp_data <= mem_rdata;
    end

    // Address/data come straight from the latched request and stay stable
    // for the whole access.
    assign mem_addr  = (state_q == ST_WB) ? req_q.victim_addr : req_q.addr;
    assign mem_wdata = req_q.victim_data;

`ifdef MISS_ENGINE_STATS_EN
    // Saturating activity counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_refills      <= '0;
            stat_writebacks   <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if ((state_q == ST_RD) && mem_ready && (stat_refills != '1))
                stat_refills <= stat_refills + 16'd1;
            if ((state_q == ST_WB) && mem_ready && (stat_writebacks != '1))
                stat_writebacks <= stat_writebacks + 16'd1;
            if ((state_q != ST_IDLE) && (stat_stall_cycles != '1))
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_miss_engine.sv
// Bench for mem_miss_engine: behavioural slow memory with programmable
// latency (0 = never ready), a response scoreboard, a vector table and
// hand-written reset/stats sequences. Watchdog limit is 8 cycles.
module tb_mem_miss_engine;

    localparam int AW = 28;
    localparam int LW = 128;
    localparam int TO = 8;

    logic          clk = 0;
    logic          rst;
    logic          req_valid, req_ready, req_dirty;
    logic [AW-1:0] req_addr, req_victim_addr;
    logic [LW-1:0] req_victim_data;
    logic          resp_valid, resp_err;
    logic [LW-1:0] resp_data;
    logic          mem_read, mem_write, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata, mem_rdata;
`ifdef MISS_ENGINE_STATS_EN
    logic [15:0]   stat_refills, stat_writebacks;
    logic [31:0]   stat_stall_cycles;
`endif

    mem_miss_engine #(
        .ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(TO), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_dirty(req_dirty), .req_victim_addr(req_victim_addr),
        .req_victim_data(req_victim_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef MISS_ENGINE_STATS_EN
        , .stat_refills(stat_refills), .stat_writebacks(stat_writebacks),
        .stat_stall_cycles(stat_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Initial memory contents are a recognisable function of the address.
    function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
        return {4'h1, a, 4'h2, a, 4'h3, a, 4'h4, a};
    endfunction

    // ---------------- behavioural slow memory ----------------
    logic [LW-1:0] mem_img [logic [AW-1:0]];
    int mem_lat = 1;
    int mcnt = 0;

    initial begin
        mem_ready = 0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (rst || !(mem_read || mem_write) || mem_ready) begin
                mem_ready = 0;
                mcnt = 0;
            end else begin
                mcnt++;
                if (mem_lat != 0 && mcnt == mem_lat) begin
                    mem_ready = 1;
                    if (mem_write) mem_img[mem_addr] = mem_wdata;
                    else mem_rdata = mem_img.exists(mem_addr) ? mem_img[mem_addr] : init_line(mem_addr);
                end
            end
        end
    end

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        logic          err;
        logic [LW-1:0] data;
        int            lat;
        int            start;
    } exp_t;
    exp_t sb[$];

    int rd_cyc = 0, wr_cyc = 0, strobe_viol = 0, busy = 0;
    logic prev_wr = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 0;
                prev_wr = 0;
            end else begin
                if (mem_read) rd_cyc++;
                if (mem_write) wr_cyc++;
                if ((mem_read && mem_write) || (mem_read && prev_wr)) strobe_viol++;
                prev_wr = mem_write;
                if (!req_ready) busy++;
                if (resp_valid || resp_err) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_resp", {resp_valid, resp_err}, 2'b00);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("resp_kind", {resp_valid, resp_err}, e.err ? 2'b01 : 2'b10);
                        chk("resp_latency", LW'(cyc - e.start + 1), LW'(e.lat));
                        if (!e.err) chk("resp_data", resp_data, e.data);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input logic [AW-1:0] a, input logic d, input logic [AW-1:0] va,
                          input logic [LW-1:0] vd, input bit push, input logic e_err,
                          input logic [LW-1:0] e_data, input int e_lat);
        int k;
        exp_t e;
        @(negedge clk);
        for (k = 0; k < 50 && !req_ready; k++) @(negedge clk);
        if (!req_ready) begin
            n_chk++;
            $display("FAIL req_ready_wait: got 0 expected 1 within 50 cycles");
        end
        req_addr = a; req_dirty = d; req_victim_addr = va; req_victim_data = vd;
        req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        req_addr = $urandom; req_victim_addr = $urandom;
        req_victim_data = {$urandom, $urandom, $urandom, $urandom};
        req_dirty = $urandom_range(0, 1);
        if (push) begin
            e.err = e_err; e.data = e_data; e.lat = e_lat; e.start = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 300 && (sb.size() != 0 || !req_ready); k++) @(negedge clk);
        if (sb.size() != 0 || !req_ready) begin
            n_chk++;
            $display("FAIL wait_done: %0d responses pending, req_ready=%0b after 300 cycles", sb.size(), req_ready);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic          dirty;
        logic [AW-1:0] va;
        logic [LW-1:0] vd;
        int            lat;     // memory latency, 0 = never ready
        logic          e_err;
        int            e_lat;   // cycles from handshake to response pulse
        int            e_rd;    // cycles mem_read high
        int            e_wr;    // cycles mem_write high
    } vec_t;

    vec_t vecs[10];
    logic [LW-1:0] ref_img [logic [AW-1:0]];

    initial begin
        logic [LW-1:0] exp_data, dead;
        int exp_rf, exp_wb;
        int k;

        dead = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        //            addr         dirty va           vd                          lat err elat rd wr
        vecs[0] = '{28'h0000010, 1'b0, 28'h0000000, '0,                         5, 1'b0, 6,  5, 0};
        vecs[1] = '{28'h0000030, 1'b1, 28'h0000020, dead,                       3, 1'b0, 8,  3, 3};
        vecs[2] = '{28'h0000040, 1'b1, 28'h0000040, {4{32'h1111_2222}},         2, 1'b0, 6,  2, 2};
        vecs[3] = '{28'h0000050, 1'b0, 28'h0000000, '0,                         1, 1'b0, 2,  1, 0};
        vecs[4] = '{28'h0000060, 1'b0, 28'h0000000, '0,                         8, 1'b0, 9,  8, 0};
        vecs[5] = '{28'h0000070, 1'b0, 28'h0000000, '0,                         0, 1'b1, 9,  8, 0};
        vecs[6] = '{28'h0000080, 1'b1, 28'h0000090, {4{32'h5555_AAAA}},         0, 1'b1, 9,  0, 8};
        vecs[7] = '{28'h00000A0, 1'b1, 28'h00000B0, {4{32'h0F0F_7777}},         8, 1'b0, 18, 8, 8};
        vecs[8] = '{28'h0000020, 1'b0, 28'h0000000, '0,                         4, 1'b0, 5,  4, 0};
        vecs[9] = '{28'h0000090, 1'b0, 28'h0000000, '0,                         2, 1'b0, 3,  2, 0};

        rst = 1; req_valid = 0; req_dirty = 0;
        req_addr = '0; req_victim_addr = '0; req_victim_data = '0;

        // reset state
        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_strobes", {mem_read, mem_write}, 0);
        chk("rst_pulses", {resp_valid, resp_err}, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk); rst = 0;
        repeat (3) @(negedge clk);
        chk("idle_req_ready", req_ready, 1);

        // reset asserted mid-read: strobe drops at once, nothing is returned
        mem_lat = 6;
        rd_cyc = 0;
        do_req(28'h0000055, 1'b0, '0, '0, 0, 0, '0, 0);
        for (k = 0; k < 20 && rd_cyc < 3; k++) begin @(negedge clk); #1; end
        chk("rst_mid_rd_active", mem_read, 1);
        #2 rst = 1;
        #1;
        chk("rst_mid_rd_strobe", {mem_read, mem_write}, 0);
        chk("rst_mid_rd_ready", req_ready, 1);
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_resp", sb.size(), 0);
        do_req(28'h0000055, 1'b0, '0, '0, 1, 0, init_line(28'h0000055), 7);
        wait_done();
        exp_rf = 1; exp_wb = 0;

        // table-driven misses
        for (int i = 0; i < 10; i++) begin
            mem_lat = vecs[i].lat;
            if (vecs[i].dirty && !vecs[i].e_err) ref_img[vecs[i].va] = vecs[i].vd;
            exp_data = ref_img.exists(vecs[i].addr) ? ref_img[vecs[i].addr] : init_line(vecs[i].addr);
            rd_cyc = 0; wr_cyc = 0;
            do_req(vecs[i].addr, vecs[i].dirty, vecs[i].va, vecs[i].vd, 1,
                   vecs[i].e_err, exp_data, vecs[i].e_lat);
            wait_done();
            chk($sformatf("v%0d_rd_cycles", i), rd_cyc, vecs[i].e_rd);
            chk($sformatf("v%0d_wr_cycles", i), wr_cyc, vecs[i].e_wr);
            chk($sformatf("v%0d_req_ready", i), req_ready, 1);
            if (vecs[i].dirty && !vecs[i].e_err) begin
                chk($sformatf("v%0d_mem_victim", i),
                    mem_img.exists(vecs[i].va) ? mem_img[vecs[i].va] : '0, vecs[i].vd);
                exp_wb++;
            end
            if (!vecs[i].e_err) exp_rf++;
        end

        chk("strobe_overlap_or_no_gap", strobe_viol, 0);
        chk("aborted_wb_not_written", mem_img.exists(28'h0000090), 0);

`ifdef MISS_ENGINE_STATS_EN
        chk("stat_refills", stat_refills, exp_rf);
        chk("stat_writebacks", stat_writebacks, exp_wb);
        chk("stat_stall_cycles", stat_stall_cycles, busy);
`else
        if (exp_rf + exp_wb == 0) $display("no completed transactions");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global guard against a hung run.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
